// File: rtl/button_conditioner.sv
// Debounced push-button conditioner: synchronizes the active-low key, filters bounce, and emits
// press/release pulses plus a wrapping press count. Long-press detection is enabled by BUTTON_CONDITIONER_LONG_PRESS_EN.
module button_conditioner #(
   parameter int debounce_limit   = 500000,
   parameter int debounce_width   = 20,
   parameter int count_width      = 8,
   parameter int long_press_limit = 50000000,
   parameter int long_press_width = 26
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic                   key_n,
   output logic                   pressed,
   output logic                   press_pulse,
   output logic                   release_pulse,
   output logic [count_width-1:0] press_count,
   output logic                   long_press
);

   // Reject parameter sets that cannot hold the terminal count.
   generate
      if (debounce_limit < 1) begin : g_bad_debounce_limit
         $error("button_conditioner: debounce_limit must be at least 1");
      end
      if ((64'd1 << debounce_width) <= 64'(debounce_limit)) begin : g_bad_debounce_width
         $error("button_conditioner: debounce_width too narrow for debounce_limit");
      end
      if (long_press_limit < 1) begin : g_bad_long_press_limit
         $error("button_conditioner: long_press_limit must be at least 1");
      end
      if ((64'd1 << long_press_width) <= 64'(long_press_limit)) begin : g_bad_long_press_width
         $error("button_conditioner: long_press_width too narrow for long_press_limit");
      end
   endgenerate

   localparam logic [debounce_width-1:0] DB_LAST = debounce_width'(debounce_limit - 1);

   logic                      sync1_q;
   logic                      sync2_q;
   logic                      sample;
   logic [debounce_width-1:0] db_cnt_q;
   logic [debounce_width-1:0] db_cnt_d;
   logic                      pressed_q;
   logic                      pressed_d;
   logic                      press_pulse_q;
   logic                      press_pulse_d;
   logic                      release_pulse_q;
   logic                      release_pulse_d;
   logic [count_width-1:0]    count_q;
   logic [count_width-1:0]    count_d;

   // Two-flop synchronizer; resets to the released level so no spurious press follows reset.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
      end else begin
         sync1_q <= key_n;
         sync2_q <= sync1_q;
      end
   end

   assign sample = ~sync2_q;

   always_comb begin
      db_cnt_d        = db_cnt_q;
      pressed_d       = pressed_q;
      press_pulse_d   = 1'b0;
      release_pulse_d = 1'b0;
      count_d         = count_q;
      if (sample == pressed_q) begin
         db_cnt_d = '0;
      end else if (db_cnt_q == DB_LAST) begin
         // Level has disagreed for debounce_limit consecutive cycles: accept it.
         db_cnt_d        = '0;
         pressed_d       = sample;
         press_pulse_d   = sample;
         release_pulse_d = ~sample;
         if (sample) begin
            count_d = count_q + 1'b1;
         end
      end else begin
         db_cnt_d = db_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         db_cnt_q        <= '0;
         pressed_q       <= 1'b0;
         press_pulse_q   <= 1'b0;
         release_pulse_q <= 1'b0;
         count_q         <= '0;
      end else begin
         db_cnt_q        <= db_cnt_d;
         pressed_q       <= pressed_d;
         press_pulse_q   <= press_pulse_d;
         release_pulse_q <= release_pulse_d;
         count_q         <= count_d;
      end
   end

   assign pressed       = pressed_q;
   assign press_pulse   = press_pulse_q;
   assign release_pulse = release_pulse_q;
   assign press_count   = count_q;

`ifdef BUTTON_CONDITIONER_LONG_PRESS_EN
   localparam logic [long_press_width-1:0] LP_LAST = long_press_width'(long_press_limit - 1);
   localparam logic [long_press_width-1:0] LP_SAT  = long_press_width'(long_press_limit);

   logic [long_press_width-1:0] hold_q;
   logic [long_press_width-1:0] hold_d;

   // hold_q counts completed pressed cycles; saturation guarantees one pulse per press.
   always_comb begin
      hold_d = hold_q;
      if (!pressed_q) begin
         hold_d = '0;
      end else if (hold_q != LP_SAT) begin
         hold_d = hold_q + 1'b1;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         hold_q <= '0;
      end else begin
         hold_q <= hold_d;
      end
   end

   assign long_press = pressed_q && (hold_q == LP_LAST);
`else
   assign long_press = 1'b0;
`endif

endmodule
